// File: rtl/lifo_stack_arbiter_pkg.sv
// Shared types and constants for the two-requester LIFO stack arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lifo_arb_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int DEPTH      = 8;
  localparam int LEVEL_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_PUSH,
    ST_PEEK,
    ST_CAPTURE,
    ST_POP,
    ST_SETTLE,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_PEEK = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_RSVD = 2'b11
  } op_t;

  // Requester id (0 = A, 1 = B) to its one-hot position on the 2-bit buses.
  function automatic logic [1:0] id2oh(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/lifo_stack_arbiter_if.sv
// Requester-side bundle: requests, ops, push data in; grant, done, error, read data out.
// Latency: n/a (wiring only).
// Backpressure: requests are only sampled while the arbiter is idle.
interface lifo_stack_arbiter_if #(
  parameter int DATA_WIDTH = 16
);
  logic [1:0]            Req_In;
  logic [1:0]            Op_A_In;
  logic [1:0]            Op_B_In;
  logic [DATA_WIDTH-1:0] Data_A_In;
  logic [DATA_WIDTH-1:0] Data_B_In;
  logic [1:0]            Gnt_Out;
  logic [1:0]            Done_Out;
  logic [1:0]            Err_Out;
  logic [DATA_WIDTH-1:0] Rd_Data_A_Out;
  logic [DATA_WIDTH-1:0] Rd_Data_B_Out;

  modport master (
    output Req_In, Op_A_In, Op_B_In, Data_A_In, Data_B_In,
    input  Gnt_Out, Done_Out, Err_Out, Rd_Data_A_Out, Rd_Data_B_Out
  );

  modport slave (
    input  Req_In, Op_A_In, Op_B_In, Data_A_In, Data_B_In,
    output Gnt_Out, Done_Out, Err_Out, Rd_Data_A_Out, Rd_Data_B_Out
  );
endinterface

// File: rtl/lifo_stack_arbiter_rr_arbiter_2.sv
// Two-way round-robin selector with an internal priority pointer (0 prefers A).
// Latency: grant is combinational from req; pointer updates on the clock after upd_en_i.
// Backpressure: none; the caller decides when a grant is consumed.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       upd_en_i,
  input  logic       upd_id_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  // Contention goes to the pointed-at requester; a lone requester always wins.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = ptr_q ? 2'b10 : 2'b01;
    end
  end

  // After a completed transaction, priority moves to the requester that was not served.
  always_comb begin
    ptr_d = ptr_q;
    if (upd_en_i) begin
      ptr_d = ~upd_id_i;
    end
  end

  // Pointer register; reset favours requester A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/lifo_stack_arbiter.sv
// Arbitrates two requesters onto one LIFO stack, sequencing peek/push/pop strobes.
// Latency: request sampled in IDLE to Done pulse: error 2, push 4, peek 4, pop 6 cycles.
// Backpressure: one transaction at a time; requests are ignored outside IDLE, never aborted.
module lifo_stack_arbiter #(
  parameter int DATA_WIDTH = lifo_arb_pkg::DATA_WIDTH,
  parameter int DEPTH      = lifo_arb_pkg::DEPTH
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  lifo_stack_arbiter_if.slave   bus,
  output logic                  Busy_Out,
  output logic [3:0]            Level_Out,
  output logic                  Stack_Push_Out,
  output logic                  Stack_Pop_Out,
  output logic                  Stack_Peek_Out,
  output logic [DATA_WIDTH-1:0] Stack_Data_Out,
  input  logic [DATA_WIDTH-1:0] Stack_Data_In,
  input  logic                  Stack_Empty_In,
  input  logic                  Stack_Full_In
);
  import lifo_arb_pkg::*;

  state_t                state_q, state_d;
  logic                  id_q, id_d;
  op_t                   op_q, op_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic [3:0]            level_q, level_d;
  logic [DATA_WIDTH-1:0] rd_a_q, rd_a_d;
  logic [DATA_WIDTH-1:0] rd_b_q, rd_b_d;

  logic [1:0] arb_gnt;
  logic       arb_upd;

  assign arb_upd = (state_q == ST_DONE);

  rr_arbiter_2 u_rr (
    .clk      (Clk_In),
    .rst_n    (Reset_In),
    .req_i    (bus.Req_In),
    .upd_en_i (arb_upd),
    .upd_id_i (id_q),
    .gnt_o    (arb_gnt)
  );

  // Next-state and datapath updates for the transaction sequencer.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    op_d    = op_q;
    data_d  = data_q;
    err_d   = err_q;
    level_d = level_q;
    rd_a_d  = rd_a_q;
    rd_b_d  = rd_b_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_gnt != 2'b00) begin
          id_d    = arb_gnt[1];
          op_d    = arb_gnt[1] ? op_t'(bus.Op_B_In) : op_t'(bus.Op_A_In);
          data_d  = arb_gnt[1] ? bus.Data_B_In : bus.Data_A_In;
          err_d   = 1'b0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if ((op_q == OP_RSVD) ||
            ((op_q == OP_PUSH) && Stack_Full_In) ||
            (((op_q == OP_POP) || (op_q == OP_PEEK)) && Stack_Empty_In)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (op_q == OP_PUSH) begin
          state_d = ST_PUSH;
        end else begin
          state_d = ST_PEEK;
        end
      end
      ST_PUSH: begin
        if (level_q != 4'(DEPTH)) begin
          level_d = level_q + 4'd1;
        end
        state_d = ST_SETTLE;
      end
      ST_PEEK: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // Stack read data is valid the cycle after the peek strobe.
        if (id_q) begin
          rd_b_d = Stack_Data_In;
        end else begin
          rd_a_d = Stack_Data_In;
        end
        state_d = (op_q == OP_POP) ? ST_POP : ST_DONE;
      end
      ST_POP: begin
        if (level_q != 4'd0) begin
          level_d = level_q - 4'd1;
        end
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any transaction in flight.
  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      state_q <= ST_IDLE;
      id_q    <= 1'b0;
      op_q    <= OP_PEEK;
      data_q  <= '0;
      err_q   <= 1'b0;
      level_q <= 4'd0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      op_q    <= op_d;
      data_q  <= data_d;
      err_q   <= err_d;
      level_q <= level_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
    end
  end

  // Outputs decode from registered state only, so strobes are exclusive and glitch-free.
  always_comb begin
    Busy_Out          = (state_q != ST_IDLE);
    bus.Gnt_Out       = Busy_Out ? id2oh(id_q) : 2'b00;
    bus.Done_Out      = (state_q == ST_DONE) ? id2oh(id_q) : 2'b00;
    bus.Err_Out       = ((state_q == ST_DONE) && err_q) ? id2oh(id_q) : 2'b00;
    bus.Rd_Data_A_Out = rd_a_q;
    bus.Rd_Data_B_Out = rd_b_q;
    Level_Out         = level_q;
    Stack_Push_Out    = (state_q == ST_PUSH);
    Stack_Pop_Out     = (state_q == ST_POP);
    Stack_Peek_Out    = (state_q == ST_PEEK);
    Stack_Data_Out    = Stack_Push_Out ? data_q : '0;
  end

endmodule

// File: tb/tb_lifo_stack_arbiter.sv
// Directed bench for lifo_stack_arbiter with a behavioural 8-deep stack attached.
// Latency: measured from the sampling edge to the Done pulse.
// Backpressure: waits for the arbiter to return to idle before each request.
module tb_lifo_stack_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lifo_stack_arbiter_if #(.DATA_WIDTH(16)) bus ();

  logic        busy;
  logic [3:0]  level;
  logic        spush, spop, speek;
  logic [15:0] sdo;
  logic [15:0] sdi;
  logic        sempty, sfull;

  lifo_stack_arbiter #(.DATA_WIDTH(16), .DEPTH(8)) dut (
    .Clk_In         (clk),
    .Reset_In       (rst_n),
    .bus            (bus),
    .Busy_Out       (busy),
    .Level_Out      (level),
    .Stack_Push_Out (spush),
    .Stack_Pop_Out  (spop),
    .Stack_Peek_Out (speek),
    .Stack_Data_Out (sdo),
    .Stack_Data_In  (sdi),
    .Stack_Empty_In (sempty),
    .Stack_Full_In  (sfull)
  );

  // Behavioural stack: flags follow the registered pointer, read data one cycle after peek.
  logic [15:0] mem [0:7];
  int          sp = 0;
  assign sempty = (sp == 0);
  assign sfull  = (sp == 8);
  initial sdi = 16'h0;
  always @(posedge clk) begin
    if (spush && sp < 8) begin
      mem[sp] <= sdo;
      sp      <= sp + 1;
    end else if (spop && sp > 0) begin
      sp <= sp - 1;
    end
    if (speek && sp > 0) sdi <= mem[sp-1];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int          r_lat, r_npush, r_npop, r_npeek, r_nexcl;
  logic [1:0]  r_done, r_err, r_gnt, r_done_next;
  logic [15:0] r_pdat;
  logic        r_tmo;

  task automatic sample_strobes();
    if (spush) begin
      r_npush++;
      r_pdat = sdo;
    end
    if (spop)  r_npop++;
    if (speek) r_npeek++;
    if ((int'(spush) + int'(spop) + int'(speek)) > 1) r_nexcl++;
  endtask

  task automatic txn(input logic [1:0] req, input logic [1:0] opa, input logic [15:0] da,
                     input logic [1:0] opb, input logic [15:0] db, input bit hold);
    int n;
    int w;
    r_npush = 0; r_npop = 0; r_npeek = 0; r_nexcl = 0; r_pdat = 16'h0;
    w = 0;
    @(negedge clk);
    while (busy && w < 50) begin
      @(negedge clk);
      w++;
    end
    bus.Req_In = req; bus.Op_A_In = opa; bus.Data_A_In = da;
    bus.Op_B_In = opb; bus.Data_B_In = db;
    @(posedge clk); #1;
    if (!hold) bus.Req_In = 2'b00;
    sample_strobes();
    n = 0;
    r_done = 2'b00;
    while (r_done == 2'b00 && n < 20) begin
      @(posedge clk); #1;
      n++;
      sample_strobes();
      r_done = bus.Done_Out;
    end
    r_tmo = (r_done == 2'b00);
    r_lat = n + 1;
    r_err = bus.Err_Out;
    r_gnt = bus.Gnt_Out;
    @(posedge clk); #1;
    r_done_next = bus.Done_Out;
  endtask

  task automatic expect_txn(input string t, input int lat, input logic [1:0] done,
                            input logic [1:0] err, input int np, input int npo, input int npk);
    chk_eq({t, "_tmo"}, 32'(r_tmo), 0);
    chk_eq({t, "_lat"}, r_lat, lat);
    chk_eq({t, "_done"}, 32'(r_done), 32'(done));
    chk_eq({t, "_err"}, 32'(r_err), 32'(err));
    chk_eq({t, "_gnt"}, 32'(r_gnt), 32'(done));
    chk_eq({t, "_npush"}, r_npush, np);
    chk_eq({t, "_npop"}, r_npop, npo);
    chk_eq({t, "_npeek"}, r_npeek, npk);
    chk_eq({t, "_excl"}, r_nexcl, 0);
    chk_eq({t, "_pulse1"}, 32'(r_done_next), 0);
  endtask

  initial begin
    int w;
    bit done_seen;
    logic [1:0] exp_g [4];
    bus.Req_In = 2'b00; bus.Op_A_In = 2'b00; bus.Op_B_In = 2'b00;
    bus.Data_A_In = 16'h0; bus.Data_B_In = 16'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_gnt", 32'(bus.Gnt_Out), 0);
    chk_eq("rst_done", 32'(bus.Done_Out), 0);
    chk_eq("rst_busy", 32'(busy), 0);
    chk_eq("rst_level", 32'(level), 0);
    chk_eq("rst_strobes", {29'h0, spush, spop, speek}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // A pops an empty stack
    txn(2'b01, 2'b10, 16'h0, 2'b00, 16'h0, 1'b0);
    expect_txn("pop_empty", 2, 2'b01, 2'b01, 0, 0, 0);

    // A pushes 1234
    txn(2'b01, 2'b01, 16'h1234, 2'b00, 16'h0, 1'b0);
    expect_txn("push_a", 4, 2'b01, 2'b00, 1, 0, 0);
    chk_eq("push_a_dat", 32'(r_pdat), 32'h1234);
    chk_eq("push_a_lvl", 32'(level), 1);

    // A pushes BEEF then pops it
    txn(2'b01, 2'b01, 16'hBEEF, 2'b00, 16'h0, 1'b0);
    expect_txn("push_beef", 4, 2'b01, 2'b00, 1, 0, 0);
    txn(2'b01, 2'b10, 16'h0, 2'b00, 16'h0, 1'b0);
    expect_txn("pop_beef", 6, 2'b01, 2'b00, 0, 1, 1);
    chk_eq("pop_beef_rd", 32'(bus.Rd_Data_A_Out), 32'hBEEF);
    chk_eq("pop_beef_lvl", 32'(level), 1);

    // A peeks 1234, then pops it
    txn(2'b01, 2'b00, 16'h0, 2'b00, 16'h0, 1'b0);
    expect_txn("peek_a", 4, 2'b01, 2'b00, 0, 0, 1);
    chk_eq("peek_a_rd", 32'(bus.Rd_Data_A_Out), 32'h1234);
    chk_eq("peek_a_lvl", 32'(level), 1);
    txn(2'b01, 2'b10, 16'h0, 2'b00, 16'h0, 1'b0);
    expect_txn("pop_a", 6, 2'b01, 2'b00, 0, 1, 1);
    chk_eq("pop_a_lvl", 32'(level), 0);

    // B fills the stack with 1..8, then a ninth push overflows
    for (int i = 1; i <= 8; i++) begin
      txn(2'b10, 2'b00, 16'h0, 2'b01, 16'(i), 1'b0);
      chk_eq("fill_err", 32'(r_err), 0);
      chk_eq("fill_dat", 32'(r_pdat), 32'(i));
    end
    chk_eq("fill_lvl", 32'(level), 8);
    txn(2'b10, 2'b00, 16'h0, 2'b01, 16'h0009, 1'b0);
    expect_txn("push_full", 2, 2'b10, 2'b10, 0, 0, 0);
    chk_eq("push_full_lvl", 32'(level), 8);

    // Reserved op from B errors without strobes
    txn(2'b10, 2'b00, 16'h0, 2'b11, 16'h0, 1'b0);
    expect_txn("rsvd_b", 2, 2'b10, 2'b10, 0, 0, 0);

    // B peeks 0008; A's read register is untouched
    txn(2'b10, 2'b00, 16'h0, 2'b00, 16'h0, 1'b0);
    expect_txn("peek_b", 4, 2'b10, 2'b00, 0, 0, 1);
    chk_eq("peek_b_rd", 32'(bus.Rd_Data_B_Out), 32'h0008);
    chk_eq("peek_b_rda", 32'(bus.Rd_Data_A_Out), 32'h1234);

    // Both requesting continuously: grants alternate starting with A
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      txn(2'b11, 2'b00, 16'h0, 2'b00, 16'h0, (i < 3));
      chk_eq("rr_tmo", 32'(r_tmo), 0);
      chk_eq("rr_done", 32'(r_done), 32'(exp_g[i]));
    end
    chk_eq("rr_rda", 32'(bus.Rd_Data_A_Out), 32'h0008);

    // Reset asserted while the pop strobe is active
    @(negedge clk);
    bus.Req_In = 2'b01; bus.Op_A_In = 2'b10;
    @(posedge clk); #1;
    bus.Req_In = 2'b00;
    w = 0;
    while (!spop && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk_eq("rst_pop_reach", 32'(spop), 1);
    rst_n = 1'b0;
    #1;
    chk_eq("rst_pop_busy", 32'(busy), 0);
    chk_eq("rst_pop_strobe", {29'h0, spush, spop, speek}, 0);
    chk_eq("rst_pop_lvl", 32'(level), 0);
    chk_eq("rst_pop_gnt", 32'(bus.Gnt_Out), 0);
    done_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.Done_Out != 2'b00) done_seen = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.Done_Out != 2'b00) done_seen = 1'b1;
    end
    chk_eq("rst_pop_nodone", 32'(done_seen), 0);
    chk_eq("rst_pop_lvl_after", 32'(level), 0);
    chk_eq("rst_pop_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
